// File: rtl/au_arb.sv
// Two-requester front end for a saturating arithmetic unit: arbitrates, issues
// one op per cycle through an issue register and holds responses until consumed.
module au_arb #(
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  cmd0,
  input  logic [3:0]  cmd1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        fwe0,
  input  logic        fwe1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  au_cmd,
  output logic [15:0] au_a,
  output logic [15:0] au_b,
  input  logic [15:0] au_result,
  input  logic        au_cout,
  input  logic        au_v,
  input  logic        au_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  logic        s1_valid_q, s1_valid_d;
  logic        s1_id_q, s1_id_d;
  logic [3:0]  s1_cmd_q, s1_cmd_d;
  logic [15:0] s1_a_q, s1_a_d;
  logic [15:0] s1_b_q, s1_b_d;
  logic        s1_fwe_q, s1_fwe_d;
  logic        last_q, last_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_v_q, flag_v_d;
  logic        flag_n_q, flag_n_d;

  logic adv;
  logic grant_ok;
  logic xfer;
  logic tie_to1;
  logic gnt0_c, gnt1_c;

  // Carry is not architectural state; only z/v/n are kept.
  logic unused_cout;
  assign unused_cout = au_cout;

  assign adv      = !rsp_valid_q || rsp_ready;
  assign grant_ok = !s1_valid_q || adv;
  assign xfer     = s1_valid_q && adv;

  // Round-robin tie goes to port 1 only when port 0 was granted last.
  assign tie_to1 = (FIXED_PRI == 0) && !last_q;
  assign gnt0_c  = !rst && grant_ok && req0 && !(req1 && tie_to1);
  assign gnt1_c  = !rst && grant_ok && req1 && (!req0 || tie_to1);

  assign gnt0 = gnt0_c;
  assign gnt1 = gnt1_c;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_cmd_d     = s1_cmd_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_fwe_d     = s1_fwe_q;
    last_d       = last_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    flag_z_d     = flag_z_q;
    flag_v_d     = flag_v_q;
    flag_n_d     = flag_n_q;

    if (gnt0_c || gnt1_c) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt1_c;
      s1_cmd_d   = gnt1_c ? cmd1 : cmd0;
      s1_a_d     = gnt1_c ? a1 : a0;
      s1_b_d     = gnt1_c ? b1 : b0;
      s1_fwe_d   = gnt1_c ? fwe1 : fwe0;
      last_d     = gnt1_c;
    end else if (xfer) begin
      // Operand fields are left untouched so the au inputs hold steady.
      s1_valid_d = 1'b0;
    end

    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = s1_id_q;
      rsp_result_d = au_result;
      if (s1_fwe_q) begin
        flag_z_d = (au_result == 16'h0000);
        flag_v_d = au_v;
        flag_n_d = au_n;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_cmd_q     <= 4'h0;
      s1_a_q       <= 16'h0000;
      s1_b_q       <= 16'h0000;
      s1_fwe_q     <= 1'b0;
      last_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'h0000;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_cmd_q     <= s1_cmd_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_fwe_q     <= s1_fwe_d;
      last_q       <= last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      flag_z_q     <= flag_z_d;
      flag_v_q     <= flag_v_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign au_cmd     = s1_cmd_q;
  assign au_a       = s1_a_q;
  assign au_b       = s1_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_au_arb.sv
// Directed bench for au_arb: a round-robin and a fixed-priority instance share
// stimulus; a behavioural saturating au closes the loop for each.
module tb_au_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  cmd0, cmd1;
  logic [15:0] a0, b0, a1, b1;
  logic        fwe0, fwe1;
  logic        rsp_ready;

  logic        gnt0, gnt1, rsp_valid, rsp_id, flag_z, flag_v, flag_n;
  logic [3:0]  au_cmd;
  logic [15:0] au_a, au_b, au_result, rsp_result;
  logic        au_cout, au_v, au_n;

  logic        gnt0_p, gnt1_p, rsp_valid_p, rsp_id_p, flag_z_p, flag_v_p, flag_n_p;
  logic [3:0]  au_cmd_p;
  logic [15:0] au_a_p, au_b_p, au_result_p, rsp_result_p;
  logic        au_cout_p, au_v_p, au_n_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Returns {cout, v, n, result}.
  function automatic logic [18:0] au_f(input logic [3:0] cmd, input logic [15:0] a,
                                       input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic [8:0]  bw;
    logic        ov, c;
    r = 16'h0000; ov = 1'b0; c = 1'b0;
    case (cmd)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b};
        c = w[16];
        ov = (a[15] == b[15]) && (w[15] != a[15]);
        r = ov ? (a[15] ? 16'h8000 : 16'h7fff) : w[15:0];
      end
      4'b0010: begin
        w = {1'b0, a} - {1'b0, b};
        c = w[16];
        ov = (a[15] != b[15]) && (w[15] != a[15]);
        r = ov ? (a[15] ? 16'h8000 : 16'h7fff) : w[15:0];
      end
      4'b1000: begin
        for (int k = 0; k < 2; k++) begin
          bw = {1'b0, a[k*8 +: 8]} + {1'b0, b[k*8 +: 8]};
          if ((a[k*8+7] == b[k*8+7]) && (bw[7] != a[k*8+7])) begin
            ov = 1'b1;
            r[k*8 +: 8] = a[k*8+7] ? 8'h80 : 8'h7f;
          end else begin
            r[k*8 +: 8] = bw[7:0];
          end
        end
      end
      default: r = 16'h0000;
    endcase
    return {c, ov, r[15], r};
  endfunction

  always_comb {au_cout, au_v, au_n, au_result} = au_f(au_cmd, au_a, au_b);
  always_comb {au_cout_p, au_v_p, au_n_p, au_result_p} = au_f(au_cmd_p, au_a_p, au_b_p);

  au_arb #(.FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fwe0(fwe0), .fwe1(fwe1),
    .gnt0(gnt0), .gnt1(gnt1), .au_cmd(au_cmd), .au_a(au_a), .au_b(au_b),
    .au_result(au_result), .au_cout(au_cout), .au_v(au_v), .au_n(au_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  au_arb #(.FIXED_PRI(1)) dut_p (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fwe0(fwe0), .fwe1(fwe1),
    .gnt0(gnt0_p), .gnt1(gnt1_p), .au_cmd(au_cmd_p), .au_a(au_a_p), .au_b(au_b_p),
    .au_result(au_result_p), .au_cout(au_cout_p), .au_v(au_v_p), .au_n(au_n_p),
    .rsp_valid(rsp_valid_p), .rsp_ready(rsp_ready), .rsp_id(rsp_id_p),
    .rsp_result(rsp_result_p), .flag_z(flag_z_p), .flag_v(flag_v_p), .flag_n(flag_n_p)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; fwe0 = 0; fwe1 = 0; rsp_ready = 0;
    #2;
    check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_rsp_result", rsp_result, 16'h0000);
    check("rst_au_a", au_a, 16'h0000);
    check("rst_flags", {13'd0, flag_z, flag_v, flag_n}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Single saturating add from port 0
    req0 = 1; cmd0 = 4'b0000; a0 = 16'h700f; b0 = 16'h7ff0; fwe0 = 1; rsp_ready = 1;
    #1;
    $display("step s1 cycle0 gnt0=%b gnt1=%b", gnt0, gnt1);
    check("s1_gnt0", {15'd0, gnt0}, 16'd1);
    check("s1_gnt1", {15'd0, gnt1}, 16'd0);
    tick(); req0 = 0; #1;
    check("s1_c1_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("s1_au_a", au_a, 16'h700f);
    tick(); #1;
    $display("step s1 cycle2 rsp_valid=%b result=%h", rsp_valid, rsp_result);
    check("s1_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    check("s1_rsp_result", rsp_result, 16'h7fff);
    check("s1_rsp_id", {15'd0, rsp_id}, 16'd0);
    check("s1_flags_zvn", {13'd0, flag_z, flag_v, flag_n}, 16'b010);
    tick(); #1;
    check("s1_rsp_cleared", {15'd0, rsp_valid}, 16'd0);
    check("s1_au_a_hold", au_a, 16'h700f);

    // Fresh reset so the first tie goes to port 0
    rst = 1; #2; rst = 0;
    tick();

    // Both requesters held: round-robin vs fixed priority
    req0 = 1; req1 = 1; cmd0 = 0; cmd1 = 0; fwe0 = 0; fwe1 = 0;
    a0 = 16'h0100; b0 = 16'h0000; a1 = 16'h0200; b1 = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin req0 = 0; req1 = 0; end
      #1;
      $display("step rr cycle%0d gnt=%b%b gnt_p=%b%b rsp_valid=%b id=%b", c, gnt1, gnt0,
               gnt1_p, gnt0_p, rsp_valid, rsp_id);
      if (c < 4) begin
        check("rr_gnt0", {15'd0, gnt0}, {15'd0, (c % 2) == 0});
        check("rr_gnt1", {15'd0, gnt1}, {15'd0, (c % 2) == 1});
        check("fp_gnt0", {15'd0, gnt0_p}, 16'd1);
        check("fp_gnt1", {15'd0, gnt1_p}, 16'd0);
      end
      if (c >= 2) begin
        check("rr_rsp_valid", {15'd0, rsp_valid}, 16'd1);
        check("rr_rsp_id", {15'd0, rsp_id}, {15'd0, ((c - 2) % 2) == 1});
        check("rr_rsp_result", rsp_result, ((c - 2) % 2) == 1 ? 16'h0200 : 16'h0100);
      end
      tick();
    end

    // Back-pressure with continuous req1
    rsp_ready = 0; req1 = 1; a1 = 16'h1234; b1 = 16'h0001; fwe1 = 0;
    #1; check("bp_gnt_a", {15'd0, gnt1}, 16'd1);
    tick(); a1 = 16'h2000; #1;
    check("bp_gnt_b", {15'd0, gnt1}, 16'd1);
    tick(); a1 = 16'h3000; #1;
    $display("step bp full gnt1=%b rsp_result=%h", gnt1, rsp_result);
    check("bp_nogrant_a", {15'd0, gnt1}, 16'd0);
    check("bp_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    check("bp_result_a", rsp_result, 16'h1235);
    check("bp_s1_hold", au_a, 16'h2000);
    tick(); #1;
    check("bp_nogrant_b", {15'd0, gnt1}, 16'd0);
    check("bp_result_b", rsp_result, 16'h1235);
    rsp_ready = 1; #1;
    check("bp_resume_gnt", {15'd0, gnt1}, 16'd1);
    tick(); req1 = 0; #1;
    check("bp_result_op2", rsp_result, 16'h2001);
    check("bp_id_op2", {15'd0, rsp_id}, 16'd1);
    tick(); #1;
    check("bp_result_op3", rsp_result, 16'h3001);
    tick(); #1;
    check("bp_drained", {15'd0, rsp_valid}, 16'd0);

    // Flag behaviour: flag-setting sub, then fwe=0 sub, zero add, paddsb
    req0 = 1; cmd0 = 4'b0010; a0 = 16'h8000; b0 = 16'h0001; fwe0 = 1; #1;
    check("fl_gnt_a", {15'd0, gnt0}, 16'd1);
    tick(); a0 = 16'h70f0; b0 = 16'h2000; fwe0 = 0; #1;
    check("fl_gnt_b", {15'd0, gnt0}, 16'd1);
    tick(); cmd0 = 4'b0000; a0 = 16'h0001; b0 = 16'hffff; fwe0 = 1; #1;
    check("fl_gnt_c", {15'd0, gnt0}, 16'd1);
    check("fl_result_a", rsp_result, 16'h8000);
    check("fl_flags_a", {13'd0, flag_z, flag_v, flag_n}, 16'b011);
    tick(); cmd0 = 4'b1000; a0 = 16'h7f01; b0 = 16'h0101; fwe0 = 0; #1;
    $display("step fl sub_nofwe result=%h zvn=%b%b%b", rsp_result, flag_z, flag_v, flag_n);
    check("fl_result_b", rsp_result, 16'h50f0);
    check("fl_flags_b", {13'd0, flag_z, flag_v, flag_n}, 16'b011);
    tick(); req0 = 0; #1;
    check("fl_result_c", rsp_result, 16'h0000);
    check("fl_flags_c", {13'd0, flag_z, flag_v, flag_n}, 16'b100);
    tick(); #1;
    check("fl_result_d", rsp_result, 16'h7f02);
    check("fl_flags_d", {13'd0, flag_z, flag_v, flag_n}, 16'b100);
    tick(); tick();

    // Reset while S1 holds a valid op
    req0 = 1; cmd0 = 4'b0000; a0 = 16'h0001; b0 = 16'h0001; fwe0 = 1; #1;
    check("mr_gnt", {15'd0, gnt0}, 16'd1);
    tick(); req0 = 0; #1;
    check("mr_s1_loaded", au_a, 16'h0001);
    rst = 1; req0 = 1; req1 = 1; #1;
    $display("step mr in_reset rsp_valid=%b au_a=%h gnt=%b%b", rsp_valid, au_a, gnt1, gnt0);
    check("mr_au_a_cleared", au_a, 16'h0000);
    check("mr_flag_z_cleared", {15'd0, flag_z}, 16'd0);
    check("mr_no_gnt", {14'd0, gnt1, gnt0}, 16'd0);
    @(posedge clk); #1;
    rst = 0; #1;
    check("mr_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("mr_flags", {13'd0, flag_z, flag_v, flag_n}, 16'd0);
    check("mr_tie_gnt0", {15'd0, gnt0}, 16'd1);
    check("mr_tie_gnt1", {15'd0, gnt1}, 16'd0);
    req0 = 0; req1 = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
